// File: rtl/dither_bit_display_buffer.sv
// dither_bit_display_buffer: shifts accepted dither bits into a nibble-per-digit display buffer
// with an operator freeze / single-step control.
module dither_bit_display_buffer #(
    parameter int DIGITS = 6,
    parameter int CNT_W  = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  pix_valid,
    input  logic                  pix_bit,
    output logic                  pix_ready,
    input  logic                  mode_freeze,
    input  logic                  step_key,
    output logic [4*DIGITS-1:0]   hex_nib,
    output logic [CNT_W-1:0]      pix_count,
    output logic                  hold_led
);
    typedef enum logic [1:0] {RUN, HOLD, STEP} state_t;
    state_t state_q, state_d;
    logic [DIGITS-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic step_prev_q;
    logic accept, step_rise;
    assign pix_ready = (state_q != HOLD);
    assign accept = pix_valid & pix_ready;
    assign step_rise = step_key & ~step_prev_q;
    assign hold_led = (state_q != RUN);
    assign pix_count = count_q;
    // Only the pixel bit is stored; the upper three bits of each nibble are constant zero.
    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        assign hex_nib[4*g +: 4] = {3'b000, bits_q[g]};
    end
    always_comb begin
        state_d = state_q;
        bits_d = accept ? {bits_q[DIGITS-2:0], pix_bit} : bits_q;
        count_d = accept ? count_q + 1'b1 : count_q;
        case (state_q)
            RUN:     state_d = mode_freeze ? HOLD : RUN;
            HOLD:    state_d = !mode_freeze ? RUN : (step_rise ? STEP : HOLD);
            STEP:    state_d = !mode_freeze ? RUN : (accept ? HOLD : STEP);
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            bits_q <= '0;
            count_q <= '0;
            step_prev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q <= bits_d;
            count_q <= count_d;
            step_prev_q <= step_key;
        end
    end
endmodule

// File: tb/tb_dither_bit_display_buffer.sv
// tb_dither_bit_display_buffer: vector table, corner sequences and randomized run against a behavioural model.
module tb_dither_bit_display_buffer;
    localparam int DIGITS = 6;
    localparam int M_RUN = 0, M_HOLD = 1, M_STEP = 2;
    logic Clk = 1'b0, Reset = 1'b0, pix_valid = 1'b0, pix_bit = 1'b0, mode_freeze = 1'b0, step_key = 1'b0;
    logic pix_ready, hold_led, pix_ready4, hold_led4;
    logic [4*DIGITS-1:0] hex_nib, hex_nib4;
    logic [9:0] pix_count;
    logic [3:0] pix_count4;
    int checks = 0, failures = 0;
    int m_mode = M_RUN, m_cnt = 0;
    logic m_hist [DIGITS];
    logic m_prev = 1'b0, m_known = 1'b0;

    dither_bit_display_buffer #(.DIGITS(DIGITS), .CNT_W(10)) dut (
        .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .pix_bit(pix_bit), .pix_ready(pix_ready),
        .mode_freeze(mode_freeze), .step_key(step_key), .hex_nib(hex_nib), .pix_count(pix_count), .hold_led(hold_led));
    dither_bit_display_buffer #(.DIGITS(DIGITS), .CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .pix_bit(pix_bit), .pix_ready(pix_ready4),
        .mode_freeze(mode_freeze), .step_key(step_key), .hex_nib(hex_nib4), .pix_count(pix_count4), .hold_led(hold_led4));

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] model_hex();
        logic [4*DIGITS-1:0] e = '0;
        for (int i = 0; i < DIGITS; i++) e[4*i] = m_hist[i];
        return e;
    endfunction

    task automatic model_step(input logic r, v, b, f, k);
        logic acc, rise;
        if (r) begin
            for (int i = 0; i < DIGITS; i++) m_hist[i] = 1'b0;
            m_cnt = 0; m_mode = M_RUN; m_prev = 1'b0; m_known = 1'b1;
            return;
        end
        acc = v && (m_mode != M_HOLD);
        rise = k && !m_prev;
        m_prev = k;
        if (acc) begin
            for (int i = DIGITS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = b;
            m_cnt++;
        end
        if (m_mode == M_RUN) m_mode = f ? M_HOLD : M_RUN;
        else if (!f) m_mode = M_RUN;
        else if (m_mode == M_HOLD) m_mode = rise ? M_STEP : M_HOLD;
        else m_mode = acc ? M_HOLD : M_STEP;
    endtask

    task automatic tick(input logic r, v, b, f, k);
        Reset = r; pix_valid = v; pix_bit = b; mode_freeze = f; step_key = k;
        #1;
        if (m_known) chk("ready_pre", 32'(pix_ready), 32'(m_mode != M_HOLD));
        @(posedge Clk);
        model_step(r, v, b, f, k);
        @(negedge Clk);
        chk("hex", 32'(hex_nib), 32'(model_hex()));
        chk("count", 32'(pix_count), 32'(m_cnt % 1024));
        chk("count4", 32'(pix_count4), 32'(m_cnt % 16));
        chk("ready", 32'(pix_ready), 32'(m_mode != M_HOLD));
        chk("hold_led", 32'(hold_led), 32'(m_mode != M_RUN));
    endtask

    typedef struct {
        logic r, v, b, f, k;
        logic [23:0] hex;
        int cnt;
        logic rdy, hold;
    } vec_t;
    vec_t vecs [$];

    task automatic add(input logic r, v, b, f, k, input logic [23:0] hex, input int cnt, input logic rdy, hold);
        vec_t t;
        t.r = r; t.v = v; t.b = b; t.f = f; t.k = k; t.hex = hex; t.cnt = cnt; t.rdy = rdy; t.hold = hold;
        vecs.push_back(t);
    endtask

    initial begin
        add(1, 0, 0, 0, 0, 24'h000000, 0, 1, 0);
        add(1, 0, 0, 0, 0, 24'h000000, 0, 1, 0);
        add(0, 0, 0, 0, 0, 24'h000000, 0, 1, 0);
        add(0, 1, 1, 0, 0, 24'h000001, 1, 1, 0);
        add(0, 1, 0, 0, 0, 24'h000010, 2, 1, 0);
        add(0, 1, 1, 0, 0, 24'h000101, 3, 1, 0);
        add(0, 1, 1, 0, 0, 24'h001011, 4, 1, 0);
        add(0, 1, 0, 0, 0, 24'h010110, 5, 1, 0);
        add(0, 1, 1, 0, 0, 24'h101101, 6, 1, 0);
        add(0, 1, 0, 0, 0, 24'h011010, 7, 1, 0);
        add(0, 1, 1, 1, 0, 24'h110101, 8, 0, 1);
        for (int i = 0; i < 10; i++) add(0, 1, 1, 1, 0, 24'h110101, 8, 0, 1);
        add(0, 1, 1, 1, 1, 24'h110101, 8, 1, 1);
        add(0, 1, 1, 1, 1, 24'h101011, 9, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 1, 24'h101011, 9, 0, 1);
        add(0, 0, 0, 0, 0, 24'h101011, 9, 1, 0);
        foreach (vecs[i]) begin
            tick(vecs[i].r, vecs[i].v, vecs[i].b, vecs[i].f, vecs[i].k);
            chk($sformatf("vec%0d_hex", i), 32'(hex_nib), 32'(vecs[i].hex));
            chk($sformatf("vec%0d_cnt", i), 32'(pix_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_rdy", i), 32'(pix_ready), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d_hold", i), 32'(hold_led), 32'(vecs[i].hold));
        end
        // Counter wrap on the 4-bit instance.
        tick(1, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            tick(0, 1, i[0], 0, 0);
            if (i == 15) chk("wrap15", 32'(pix_count4), 32'd15);
            if (i == 16) chk("wrap16", 32'(pix_count4), 32'd0);
        end
        chk("wrap17", 32'(pix_count4), 32'd1);
        chk("wrap17_wide", 32'(pix_count), 32'd17);
        // Reset while in STEP with a beat presented.
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 1);
        chk("in_step_ready", 32'(pix_ready), 32'd1);
        chk("in_step_hold", 32'(hold_led), 32'd1);
        tick(1, 1, 1, 1, 1);
        chk("rst_hex", 32'(hex_nib), 32'd0);
        chk("rst_cnt", 32'(pix_count), 32'd0);
        chk("rst_ready", 32'(pix_ready), 32'd1);
        chk("rst_hold", 32'(hold_led), 32'd0);
        // Accept in STEP while freeze drops: beat taken, back to RUN.
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 1);
        tick(0, 1, 1, 0, 1);
        chk("stepdrop_cnt", 32'(pix_count), 32'd1);
        chk("stepdrop_hold", 32'(hold_led), 32'd0);
        for (int n = 0; n < 600; n++) begin
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
